// File: rtl/jc_pkg.sv
// Shared constants and helpers for the parametrised Johnson/ring counter.
package jc_pkg;

  localparam logic MODE_JOHNSON = 1'b0;
  localparam logic MODE_RING    = 1'b1;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // Reset pattern is all-zeros (Johnson) or a single one in bit 0 (ring);
  // only bit 0 differs between the two, so the helper returns that bit.
  function automatic logic jc_reset_lsb(input logic mode);
    return (mode == MODE_RING);
  endfunction

endpackage

// File: rtl/jc_decode.sv
// Combinational phase decode: legality, binary phase index and one-hot phase.
module jc_decode
  import jc_pkg::*;
#(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned IDXW  = $clog2(2*WIDTH)
) (
  input  logic [WIDTH-1:0]   q_i,
  input  logic               mode_i,
  output logic               legal_o,
  output logic [IDXW-1:0]    phase_idx_o,
  output logic [2*WIDTH-1:0] phase_o
);

  logic [IDXW-1:0] ones;
  logic [IDXW-1:0] ring_pos;
  logic [IDXW-1:0] idx;
  logic            one_edge;
  logic            multi_edge;
  logic            legal;

  // Popcount, set-bit position and adjacent-bit transition scan of q.
  always_comb begin
    ones       = '0;
    ring_pos   = '0;
    one_edge   = 1'b0;
    multi_edge = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      ones = ones + IDXW'(q_i[i]);
      if (q_i[i]) ring_pos = IDXW'(i);
    end
    // A thermometer code (either justification) has at most one 0/1 boundary.
    for (int unsigned i = 0; i + 1 < WIDTH; i++) begin
      if (q_i[i] != q_i[i+1]) begin
        if (one_edge) multi_edge = 1'b1;
        one_edge = 1'b1;
      end
    end
  end

  // Mode-dependent legality and index, then one-hot expansion.
  always_comb begin
    legal   = 1'b0;
    idx     = '0;
    phase_o = '0;
    if (mode_i == MODE_RING) begin
      legal = (ones == IDXW'(1));
      idx   = ring_pos;
    end else begin
      legal = !multi_edge;
      if (q_i[0])            idx = ones;
      else if (ones == '0)   idx = '0;
      else                   idx = IDXW'(2*WIDTH) - ones;
    end
    if (!legal) idx = '0;
    else        phase_o[idx] = 1'b1;
  end

  assign legal_o     = legal;
  assign phase_idx_o = idx;

endmodule

// File: rtl/johnson_counter_param.sv
// Parametrised Johnson/ring counter with direction, load and self-correction.
module johnson_counter_param
  import jc_pkg::*;
#(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned IDXW  = $clog2(2*WIDTH)
) (
  input  logic               CLK,
  input  logic               reset_n,
  input  logic               en,
  input  logic               mode,
  input  logic               dir,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  output logic [WIDTH-1:0]   q,
  output logic [2*WIDTH-1:0] phase,
  output logic [IDXW-1:0]    phase_idx,
  output logic               legal,
  output logic               wrap,
  output logic               corrected
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             corr_q, corr_d;
  logic [WIDTH-1:0] rst_val;
  logic [WIDTH-1:0] step;

  jc_decode #(.WIDTH(WIDTH)) u_decode (
    .q_i         (q_q),
    .mode_i      (mode),
    .legal_o     (legal),
    .phase_idx_o (phase_idx),
    .phase_o     (phase)
  );

  // Reset pattern for the current mode and the one-step successor of q.
  always_comb begin
    rst_val    = '0;
    rst_val[0] = jc_reset_lsb(mode);
    unique case ({mode, dir})
      {MODE_JOHNSON, DIR_FWD}: step = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
      {MODE_JOHNSON, DIR_REV}: step = {~q_q[0], q_q[WIDTH-1:1]};
      {MODE_RING,    DIR_FWD}: step = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      default:                 step = {q_q[0], q_q[WIDTH-1:1]};
    endcase
  end

  // Next state with priority load > en > hold; wrap fires when a step lands
  // on index 0, which in both modes is exactly the reset pattern.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    corr_d = 1'b0;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
      if (legal) begin
        q_d    = step;
        wrap_d = (step == rst_val);
      end else begin
        q_d    = rst_val;
        corr_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      q_q    <= rst_val;
      wrap_q <= 1'b0;
      corr_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      corr_q <= corr_d;
    end
  end

  assign q         = q_q;
  assign wrap      = wrap_q;
  assign corrected = corr_q;

endmodule
